// File: rtl/systolic_array_seq_ctrl.sv
// systolic_array_seq_ctrl: job sequencer for the 1xN weight-stationary column.
// Optional job cycle counter is built when SA_SEQ_CTRL_PERF_EN is defined.
module systolic_array_seq_ctrl #(
  parameter int BN_NUM   = 10,
  parameter int ACCU_NUM = 5,
  parameter int PIPE_LAT = 10,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        cfg_shift_num,
  output logic              busy,
  output logic              done,
  output logic              wet_rd_en,
  output logic [ADDR_W-1:0] wet_rd_addr,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_rd_addr,
  output logic              PE_mac_enable,
  output logic              PE_clear_acc,
  output logic              PE_weight_partial_sel,
  output logic [7:0]        PE_res_shift_num,
  output logic              res_wr_en,
  output logic [ADDR_W-1:0] res_wr_addr,
  output logic [31:0]       perf_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(ACCU_NUM - 1);
  localparam logic [ADDR_W-1:0] B_LAST = ADDR_W'(BN_NUM - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [PIPE_LAT-1:0] pipe_q, pipe_d;
  logic [7:0]          shift_q, shift_d;
  logic                accept;

  always_comb begin
    busy                  = 1'b0;
    done                  = 1'b0;
    wet_rd_en             = 1'b0;
    wet_rd_addr           = '0;
    act_rd_en             = 1'b0;
    act_rd_addr           = '0;
    PE_mac_enable         = 1'b0;
    PE_clear_acc          = 1'b0;
    PE_weight_partial_sel = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_CLEAR: begin
        busy         = 1'b1;
        PE_clear_acc = 1'b1;
      end
      S_LOAD_W: begin
        busy                  = 1'b1;
        wet_rd_en             = 1'b1;
        wet_rd_addr           = cnt_q;
        PE_weight_partial_sel = 1'b1;
      end
      S_STREAM: begin
        busy          = 1'b1;
        act_rd_en     = 1'b1;
        act_rd_addr   = cnt_q;
        PE_mac_enable = 1'b1;
      end
      S_DRAIN: begin
        busy          = 1'b1;
        PE_mac_enable = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Result strobe is the tap of the read-strobe delay line.
  assign res_wr_en        = pipe_q[PIPE_LAT-1];
  assign res_wr_addr      = res_wr_en ? wr_cnt_q : '0;
  assign PE_res_shift_num = shift_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    accept    = 1'b0;
    wr_cnt_d  = res_wr_en ? wr_cnt_q + 1'b1 : wr_cnt_q;
    pipe_d    = pipe_q << 1;
    pipe_d[0] = act_rd_en;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          accept  = 1'b1;
        end
      end
      S_CLEAR: state_d = S_LOAD_W;
      S_LOAD_W: begin
        if (cnt_q == W_LAST) state_d = S_STREAM;
        else cnt_d = cnt_q + 1'b1;
      end
      S_STREAM: begin
        if (cnt_q == B_LAST) state_d = S_DRAIN;
        else cnt_d = cnt_q + 1'b1;
      end
      S_DRAIN: begin
        if (res_wr_en && wr_cnt_q == B_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        wr_cnt_d = '0;
        if (start) begin
          state_d = S_CLEAR;
          accept  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      wr_cnt_d = '0;
      pipe_d   = '0;
      accept   = 1'b0;
    end
    shift_d = accept ? cfg_shift_num : shift_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_cnt_q <= '0;
      pipe_q   <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_cnt_q <= wr_cnt_d;
      pipe_q   <= pipe_d;
      shift_q  <= shift_d;
    end
  end

`ifdef SA_SEQ_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (accept) perf_d = '0;
    else if (busy) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perf_q <= '0;
    else perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule
